instr_fetch: RTL and testbench

Fetch stage of the 2-stage RV32I pipeline. Owns the program counter and issues one-at-a-time requests on the instruction-memory request/response interface. Delivers `instruction`, `pc_address` and `valid` to the decode stage, which consumes them as its inputs. Accepts stall and redirect (taken branch/jal/jalr) back from decode.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_hold_buf.sv | 34 +++
 rtl/instr_fetch.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_DROP,
        ST_FAULT
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instruction/pc buffer that parks a response while decode is stalled.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic        clr,
    input  logic [31:0] wr_data,
    input  logic [31:0] wr_pc,
    output logic [31:0] data,
    output logic [31:0] pc,
    output logic        full
);

    // clr wins over wr_en so a redirect always flushes a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= NOP_INSTR;
            pc   <= DEFAULT_RESET_PC;
            full <= 1'b0;
        end else if (clr) begin
            full <= 1'b0;
        end else if (wr_en) begin
            data <= wr_data;
            pc   <= wr_pc;
            full <= 1'b1;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one imem request at a time, feeds decode.
// Optional misaligned-redirect fault enabled by INSTR_FETCH_MISALIGN_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] pc_address,
    output logic        valid
`ifdef INSTR_FETCH_MISALIGN_EN
    ,
    output logic        misaligned_fault
`endif
);

    // Handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
    // addr stays stable until then. Responses are single-cycle pulses that cannot be
    // backpressured, so the FSM must always be able to absorb one while in WAIT/DROP.

    fetch_state_e state, state_n;
    logic [31:0]  fetch_pc, fetch_pc_n;
    logic [31:0]  instr_n, pc_n;
    logic         valid_n;

    logic         buf_wr, buf_rd, buf_clr, buf_full;
    logic [31:0]  buf_data, buf_pc;

    logic         req_fire, out_free, outstanding, redir_bad;
    logic [31:0]  redir_target;

    assign imem_req_valid = (state == ST_ISSUE) && !rst;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign out_free       = !valid || !stall;
    assign redir_target   = redirect_pc & ~32'h3;

    // A request is in flight if we are waiting on it or one was just accepted.
    assign outstanding = ((state == ST_WAIT) || (state == ST_DROP) ||
                          ((state == ST_ISSUE) && req_fire)) && !imem_rsp_valid;

`ifdef INSTR_FETCH_MISALIGN_EN
    assign redir_bad        = (redirect_pc[1:0] != 2'b00);
    assign misaligned_fault = (state == ST_FAULT);
`else
    assign redir_bad        = 1'b0;
`endif

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_wr),
        .rd_en   (buf_rd),
        .clr     (buf_clr),
        .wr_data (imem_rsp_data),
        .wr_pc   (fetch_pc),
        .data    (buf_data),
        .pc      (buf_pc),
        .full    (buf_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ISSUE;
            fetch_pc    <= RESET_PC;
            instruction <= NOP_INSTR;
            pc_address  <= RESET_PC;
            valid       <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            instruction <= instr_n;
            pc_address  <= pc_n;
            valid       <= valid_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        instr_n    = instruction;
        pc_n       = pc_address;
        valid_n    = valid;
        buf_wr     = 1'b0;
        buf_rd     = 1'b0;
        buf_clr    = 1'b0;

        // Decode consumed the current output; retire it unless replaced below.
        if (valid && !stall) begin
            valid_n = 1'b0;
            instr_n = NOP_INSTR;
        end

        unique case (state)
            ST_ISSUE: begin
                if (req_fire) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    fetch_pc_n = fetch_pc + PC_INCR;
                    if (out_free) begin
                        instr_n = imem_rsp_data;
                        pc_n    = fetch_pc;
                        valid_n = 1'b1;
                        state_n = ST_ISSUE;
                    end else begin
                        buf_wr  = 1'b1;
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    if (buf_full) begin
                        instr_n = buf_data;
                        pc_n    = buf_pc;
                        valid_n = 1'b1;
                        buf_rd  = 1'b1;
                    end
                    state_n = ST_ISSUE;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) state_n = ST_ISSUE;
            end
            ST_FAULT: begin
                valid_n = 1'b0;
                instr_n = NOP_INSTR;
            end
            default: state_n = ST_ISSUE;
        endcase

        // Redirect overrides stall and any same-cycle response.
        if (redirect && (state != ST_FAULT)) begin
            valid_n = 1'b0;
            instr_n = NOP_INSTR;
            buf_clr = 1'b1;
            buf_wr  = 1'b0;
            buf_rd  = 1'b0;
            if (redir_bad) begin
                state_n    = ST_FAULT;
                fetch_pc_n = fetch_pc;
            end else begin
                fetch_pc_n = redir_target;
                state_n    = outstanding ? ST_DROP : ST_ISSUE;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a variable-latency instruction memory model.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc_address;
  logic        valid;
`ifdef INSTR_FETCH_MISALIGN_EN
  logic        misaligned_fault;
`endif

  int          total_checks;
  int          passed_checks;
  int          mem_lat;
  int          pend;
  logic [31:0] pend_addr;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instruction    (instruction),
    .pc_address     (pc_address),
    .valid          (valid)
`ifdef INSTR_FETCH_MISALIGN_EN
    ,
    .misaligned_fault (misaligned_fault)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; memory answers mem_lat cycles after an accepted request.
  task automatic step();
    logic        hs;
    logic [31:0] ha;
    logic        rs;
    hs = imem_req_valid && imem_req_ready;
    ha = imem_req_addr;
    rs = rst;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (rs) pend = 0;
    else if (hs) begin
      pend      = mem_lat;
      pend_addr = ha;
    end
    if (pend != 0) begin
      pend--;
      if (pend == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(pend_addr);
      end
    end
  endtask

  initial begin
    total_checks   = 0;
    passed_checks  = 0;
    mem_lat        = 1;
    pend           = 0;
    pend_addr      = '0;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;

    // reset
    step();
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_valid", valid, 0);
    chk("rst_instr", instruction, NOP_INSTR);
    chk("rst_pc", pc_address, 32'h0);
    chk("rst_state", 32'(dut.state), 32'(ST_ISSUE));
`ifdef INSTR_FETCH_MISALIGN_EN
    chk("rst_fault", misaligned_fault, 0);
`endif

    // cycle 1: first request at 0
    rst = 1'b0;
    #1;
    chk("c1_req_valid", imem_req_valid, 1);
    chk("c1_req_addr", imem_req_addr, 32'h0);
    step();
    // cycle 2: waiting
    #1;
    chk("c2_req_valid", imem_req_valid, 0);
    chk("c2_valid", valid, 0);
    step();
    // cycle 3: first instruction out, next request at 4, memory not ready
    imem_req_ready = 1'b0;
    #1;
    chk("c3_valid", valid, 1);
    chk("c3_instr", instruction, 32'h0050_0093);
    chk("c3_pc", pc_address, 32'h0);
    chk("c3_req_addr", imem_req_addr, 32'h4);
    step();
    #1;
    chk("c4_valid_drop", valid, 0);
    chk("c4_instr_nop", instruction, NOP_INSTR);
    chk("c4_req_valid", imem_req_valid, 1);
    chk("c4_req_addr", imem_req_addr, 32'h4);
    step();
    #1;
    chk("c5_req_addr", imem_req_addr, 32'h4);
    chk("c5_state", 32'(dut.state), 32'(ST_ISSUE));
    step();
    imem_req_ready = 1'b1;
    #1;
    chk("c6_req_addr", imem_req_addr, 32'h4);
    step();
    #1;
    chk("c7_state", 32'(dut.state), 32'(ST_WAIT));
    step();

    // cycle 8: pc 4 out, stall while response for 8 arrives
    stall = 1'b1;
    #1;
    chk("c8_pc", pc_address, 32'h4);
    chk("c8_instr", instruction, 32'hA5A5_0004);
    chk("c8_req_addr", imem_req_addr, 32'h8);
    step();
    #1;
    chk("c9_pc_hold", pc_address, 32'h4);
    step();
    #1;
    chk("c10_state", 32'(dut.state), 32'(ST_HOLD));
    chk("c10_pc", pc_address, 32'h4);
    chk("c10_valid", valid, 1);
    chk("c10_req_valid", imem_req_valid, 0);
    step();
    stall = 1'b0;
    #1;
    chk("c11_pc", pc_address, 32'h4);
    step();
    // cycle 12: buffered pc 8 delivered
    stall   = 1'b1;
    mem_lat = 2;
    #1;
    chk("c12_valid", valid, 1);
    chk("c12_pc", pc_address, 32'h8);
    chk("c12_instr", instruction, 32'hA5A5_0008);
    chk("c12_req_addr", imem_req_addr, 32'hC);
    step();

    // cycle 13: redirect in WAIT with stall held
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("c13_state", 32'(dut.state), 32'(ST_WAIT));
    chk("c13_valid", valid, 1);
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    mem_lat  = 1;
    #1;
    chk("c14_state", 32'(dut.state), 32'(ST_DROP));
    chk("c14_valid", valid, 0);
    chk("c14_instr", instruction, NOP_INSTR);
    chk("c14_req_valid", imem_req_valid, 0);
    step();
    #1;
    chk("c15_valid", valid, 0);
    chk("c15_req_valid", imem_req_valid, 1);
    chk("c15_req_addr", imem_req_addr, 32'h100);
    step();
    step();
    // cycle 17: target instruction out, then fill the hold buffer
    stall = 1'b1;
    #1;
    chk("c17_pc", pc_address, 32'h100);
    chk("c17_instr", instruction, 32'hA5A5_0100);
    chk("c17_req_addr", imem_req_addr, 32'h104);
    step();
    step();
    // cycle 19: redirect while stalled with buffer full
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("c19_state", 32'(dut.state), 32'(ST_HOLD));
    chk("c19_buf_full", dut.buf_full, 1);
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    #1;
    chk("c20_valid", valid, 0);
    chk("c20_buf_full", dut.buf_full, 0);
    chk("c20_req_addr", imem_req_addr, 32'h200);
    chk("c20_req_valid", imem_req_valid, 1);
    step();
    step();

    // cycle 22: redirect on a same-cycle handshake -> stale response dropped
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("c22_pc", pc_address, 32'h200);
    chk("c22_instr", instruction, 32'hA5A5_0200);
    step();
    redirect = 1'b0;
    #1;
    chk("c23_state", 32'(dut.state), 32'(ST_DROP));
    chk("c23_valid", valid, 0);
    step();
    #1;
    chk("c24_valid", valid, 0);
    chk("c24_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    step();
    step();
    // cycle 26: top of address space, PC wraps
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h102;
    #1;
    chk("c26_pc", pc_address, 32'hFFFF_FFFC);
    chk("c26_instr", instruction, 32'h5A5A_FFFC);
    chk("c26_req_addr_wrap", imem_req_addr, 32'h0);
    step();

    // cycle 27: misaligned redirect target
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat        = 2;
    #1;
    chk("c27_valid", valid, 0);
`ifdef INSTR_FETCH_MISALIGN_EN
    chk("c27_fault", misaligned_fault, 1);
    chk("c27_req_valid", imem_req_valid, 0);
`else
    chk("c27_req_valid", imem_req_valid, 1);
    chk("c27_req_addr", imem_req_addr, 32'h100);
`endif
    step();

    // cycle 28: reset mid-transaction
    rst = 1'b1;
    #1;
    chk("c28_req_valid_rst", imem_req_valid, 0);
`ifdef INSTR_FETCH_MISALIGN_EN
    chk("c28_fault_sticky", misaligned_fault, 1);
`endif
    step();
    rst     = 1'b0;
    mem_lat = 1;
    #1;
    chk("c29_state", 32'(dut.state), 32'(ST_ISSUE));
    chk("c29_req_valid", imem_req_valid, 1);
    chk("c29_req_addr", imem_req_addr, 32'h0);
    chk("c29_valid", valid, 0);
    chk("c29_pc", pc_address, 32'h0);
`ifdef INSTR_FETCH_MISALIGN_EN
    chk("c29_fault_clr", misaligned_fault, 0);
`endif
    step();
    step();
    #1;
    chk("c31_valid", valid, 1);
    chk("c31_instr", instruction, 32'h0050_0093);
    chk("c31_pc", pc_address, 32'h0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
